// File: rtl/matrix_bank_stream.sv
// Banked DIM x DIM register file: 1-cycle row/column writes, whole-bank streaming (row or column order), 1-cycle start latency.
// out_valid/out_ready holds the beat on stall; writes to the streaming bank are refused. Define MATRIX_BANK_CLEAR_EN for single-cycle bank clear.
module matrix_bank_stream #(
   parameter int WORD_W = 32,
   parameter int DIM    = 16,
   parameter int BANKS  = 2,
   parameter int BW     = (BANKS > 1) ? $clog2(BANKS) : 1,
   parameter int IW     = $clog2(DIM)
) (
   input  logic                  clk,
   input  logic                  RESET,
   input  logic                  wr_en,
   output logic                  wr_ready,
   input  logic [BW-1:0]         wr_bank,
   input  logic [IW-1:0]         wr_idx,
   input  logic                  wr_col_mode,
   input  logic [DIM*WORD_W-1:0] wr_data,
`ifdef MATRIX_BANK_CLEAR_EN
   input  logic                  clr_en,
   input  logic [BW-1:0]         clr_bank,
`endif
   input  logic                  rd_start,
   input  logic [BW-1:0]         rd_bank,
   input  logic                  rd_transpose,
   output logic                  rd_busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIM*WORD_W-1:0] out_data,
   output logic [IW-1:0]         out_idx,
   output logic                  out_last
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         bank_q, bank_d;
   logic                  tr_q, tr_d;
   logic [IW-1:0]         out_idx_q, out_idx_d;
   logic [DIM*WORD_W-1:0] out_data_q, out_data_d;

   logic [WORD_W-1:0]     mem_view [BANKS][DIM][DIM];
   logic [DIM*WORD_W-1:0] beat_sel;
   logic [BW-1:0]         sel_bank;
   logic [IW-1:0]         sel_idx;
   logic                  sel_tr;
   logic                  load;
   logic                  busy;
   logic                  wr_bank_ok, rd_bank_ok;
   logic                  wr_fire;
   logic                  clr_fire;
   logic [BW-1:0]         clr_sel;

   assign busy       = (state_q == STREAM);
   assign wr_bank_ok = ({1'b0, wr_bank} < (BW+1)'(BANKS));
   assign rd_bank_ok = ({1'b0, rd_bank} < (BW+1)'(BANKS));
   assign wr_ready   = wr_bank_ok && !(busy && (wr_bank == bank_q));
   assign wr_fire    = wr_en && wr_ready;

`ifdef MATRIX_BANK_CLEAR_EN
   assign clr_fire = clr_en && ({1'b0, clr_bank} < (BW+1)'(BANKS))
                     && !(busy && (clr_bank == bank_q));
   assign clr_sel  = clr_bank;
`else
   assign clr_fire = 1'b0;
   assign clr_sel  = '0;
`endif

   // One register per element so a row write and a column write are both plain per-cell enables.
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      for (genvar r = 0; r < DIM; r++) begin : g_row
         for (genvar c = 0; c < DIM; c++) begin : g_col
            logic [WORD_W-1:0] cell_q;
            logic              row_we, col_we, clr_hit;

            assign clr_hit = clr_fire && (clr_sel == BW'(b));
            assign row_we  = wr_fire && !wr_col_mode && (wr_bank == BW'(b)) && (wr_idx == IW'(r));
            assign col_we  = wr_fire &&  wr_col_mode && (wr_bank == BW'(b)) && (wr_idx == IW'(c));

            always_ff @(posedge clk or negedge RESET) begin
               if (!RESET) begin
                  cell_q <= '0;
               end else if (clr_hit) begin
                  cell_q <= '0;
               end else if (row_we) begin
                  cell_q <= wr_data[c*WORD_W +: WORD_W];
               end else if (col_we) begin
                  cell_q <= wr_data[r*WORD_W +: WORD_W];
               end
            end

            assign mem_view[b][r][c] = cell_q;
         end
      end
   end

   always_comb begin
      beat_sel = '0;
      for (int e = 0; e < DIM; e++) begin
         if (sel_tr) begin
            beat_sel[e*WORD_W +: WORD_W] = mem_view[sel_bank][e][sel_idx];
         end else begin
            beat_sel[e*WORD_W +: WORD_W] = mem_view[sel_bank][sel_idx][e];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      tr_d      = tr_q;
      out_idx_d = out_idx_q;
      load      = 1'b0;
      sel_bank  = rd_bank;
      sel_tr    = rd_transpose;
      sel_idx   = '0;
      case (state_q)
         IDLE: begin
            if (rd_start && rd_bank_ok) begin
               state_d   = STREAM;
               bank_d    = rd_bank;
               tr_d      = rd_transpose;
               out_idx_d = '0;
               load      = 1'b1;
            end
         end
         STREAM: begin
            sel_bank = bank_q;
            sel_tr   = tr_q;
            sel_idx  = out_idx_q + IW'(1);
            if (out_ready) begin
               if (out_idx_q == IW'(DIM-1)) begin
                  state_d = IDLE;
               end else begin
                  out_idx_d = out_idx_q + IW'(1);
                  load      = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      out_data_d = load ? beat_sel : out_data_q;
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         bank_q     <= '0;
         tr_q       <= 1'b0;
         out_idx_q  <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         tr_q       <= tr_d;
         out_idx_q  <= out_idx_d;
         out_data_q <= out_data_d;
      end
   end

   assign rd_busy   = busy;
   assign out_valid = busy;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = busy && (out_idx_q == IW'(DIM-1));

endmodule

// File: tb/tb_matrix_bank_stream.sv
// Directed, table-driven bench for matrix_bank_stream (WORD_W=32, DIM=16, BANKS=2).
module tb_matrix_bank_stream;
   localparam int WORD_W = 32;
   localparam int DIM    = 16;
   localparam int DW     = DIM*WORD_W;
   localparam logic [31:0] A5 = 32'hA5A5A5A5;

   localparam int K_ROW  = 0;   // beat k elem e = k*16+e
   localparam int K_COL  = 1;   // beat k elem e = e*16+k
   localparam int K_A5R  = 2;   // elem 3 = A5, rest 0
   localparam int K_A5T  = 3;   // beat 3 all A5, rest 0
   localparam int K_ZERO = 4;
   localparam int K_B1W  = 5;   // row 0 = 0x100+e, else column 3 = A5

   logic          clk = 1'b0;
   logic          RESET;
   logic          wr_en, wr_ready, wr_col_mode;
   logic [0:0]    wr_bank;
   logic [3:0]    wr_idx;
   logic [DW-1:0] wr_data;
   logic          rd_start, rd_transpose, rd_busy;
   logic [0:0]    rd_bank;
   logic          out_valid, out_ready, out_last;
   logic [DW-1:0] out_data;
   logic [3:0]    out_idx;
`ifdef MATRIX_BANK_CLEAR_EN
   logic          clr_en;
   logic [0:0]    clr_bank;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   matrix_bank_stream #(.WORD_W(32), .DIM(16), .BANKS(2)) dut (
      .clk(clk), .RESET(RESET),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_bank(wr_bank), .wr_idx(wr_idx),
      .wr_col_mode(wr_col_mode), .wr_data(wr_data),
`ifdef MATRIX_BANK_CLEAR_EN
      .clr_en(clr_en), .clr_bank(clr_bank),
`endif
      .rd_start(rd_start), .rd_bank(rd_bank), .rd_transpose(rd_transpose),
      .rd_busy(rd_busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
   );

   typedef struct {
      int         bank;
      int         tr;
      logic [3:0] pat;
      int         kind;
      bit         do_wr;
   } stream_vec_t;

   stream_vec_t tbl [8];

   task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_elem(input int kind, input int k, input int e);
      case (kind)
         K_ROW:   return 32'(k*16 + e);
         K_COL:   return 32'(e*16 + k);
         K_A5R:   return (e == 3) ? A5 : 32'h0;
         K_A5T:   return (k == 3) ? A5 : 32'h0;
         K_B1W:   return (k == 0) ? 32'(32'h100 + e) : ((e == 3) ? A5 : 32'h0);
         default: return 32'h0;
      endcase
   endfunction

   // Called just after a negedge; returns just after the following negedge.
   task automatic write_vec(input int b, input int idx, input bit col,
                            input logic [DW-1:0] d, input bit exp_rdy);
      wr_en = 1'b1; wr_bank = 1'(b); wr_idx = 4'(idx); wr_col_mode = col; wr_data = d;
      #1 chk("wr_ready", 600'(wr_ready), 600'(exp_rdy));
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic fill_rows(input int b);
      logic [DW-1:0] d;
      for (int r = 0; r < DIM; r++) begin
         for (int e = 0; e < DIM; e++) d[e*32 +: 32] = 32'(r*16 + e);
         write_vec(b, r, 1'b0, d, 1'b1);
      end
   endtask

   task automatic run_stream(input int b, input int tr, input logic [3:0] pat,
                             input int kind, input bit do_wr, input bit do_clr);
      int k = 0;
      int cyc = 0;
      logic [DW-1:0] eb;
      logic [DW-1:0] d;
      rd_start = 1'b1; rd_bank = 1'(b); rd_transpose = tr[0]; out_ready = 1'b0;
      @(negedge clk);
      rd_start = 1'b0;
      chk("start_latency", 600'({rd_busy, out_valid}), 600'(2'b11));
      while (k < DIM && cyc < 200) begin
         wr_en = 1'b0; rd_start = 1'b0;
`ifdef MATRIX_BANK_CLEAR_EN
         clr_en = do_clr && (cyc == 3);
         clr_bank = 1'(b);
`endif
         for (int e = 0; e < DIM; e++) eb[e*32 +: 32] = exp_elem(kind, k, e);
         chk("beat", {82'd0, out_valid, out_last, out_idx, out_data},
             {82'd0, 1'b1, (k == DIM-1), 4'(k), eb});
         if (do_wr && (cyc == 4 || cyc == 5)) begin
            wr_en = 1'b1; wr_bank = 1'(b); wr_col_mode = (cyc == 5);
            wr_idx = (cyc == 5) ? 4'd2 : 4'd0; wr_data = '1;
            rd_start = 1'b1; rd_bank = 1'(1 - b); rd_transpose = 1'b0;
            #1 chk("wr_ready_busy_bank", 600'(wr_ready), 600'(0));
         end
         if (do_wr && cyc == 6) begin
            for (int e = 0; e < DIM; e++) d[e*32 +: 32] = 32'(32'h100 + e);
            wr_en = 1'b1; wr_bank = 1'(1 - b); wr_col_mode = 1'b0; wr_idx = 4'd0; wr_data = d;
            #1 chk("wr_ready_other_bank", 600'(wr_ready), 600'(1));
         end
         out_ready = pat[cyc % 4];
         if (out_ready && k == DIM-1) begin
            rd_start = 1'b1; rd_bank = 1'(b);
         end
         if (out_ready) k++;
         cyc++;
         @(negedge clk);
      end
      wr_en = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
`ifdef MATRIX_BANK_CLEAR_EN
      clr_en = 1'b0;
`endif
      if (cyc >= 200) begin
         failures++;
         $display("FAIL stream_timeout beats=%0d required=%0d", k, DIM);
      end
      chk("stream_end", 600'({rd_busy, out_valid, out_last}), 600'(0));
   endtask

   initial begin
      logic [DW-1:0] d;
      int guard;
      tbl[0] = '{bank: 0, tr: 0, pat: 4'b1111, kind: K_ROW,  do_wr: 1'b0};
      tbl[1] = '{bank: 0, tr: 1, pat: 4'b1111, kind: K_COL,  do_wr: 1'b0};
      tbl[2] = '{bank: 1, tr: 0, pat: 4'b1111, kind: K_A5R,  do_wr: 1'b0};
      tbl[3] = '{bank: 1, tr: 1, pat: 4'b0110, kind: K_A5T,  do_wr: 1'b0};
      tbl[4] = '{bank: 0, tr: 0, pat: 4'b1001, kind: K_ROW,  do_wr: 1'b0};
      tbl[5] = '{bank: 0, tr: 0, pat: 4'b1111, kind: K_ROW,  do_wr: 1'b1};
      tbl[6] = '{bank: 0, tr: 1, pat: 4'b1011, kind: K_COL,  do_wr: 1'b0};
      tbl[7] = '{bank: 1, tr: 0, pat: 4'b1111, kind: K_B1W,  do_wr: 1'b0};

      RESET = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_idx = '0; wr_col_mode = 1'b0;
      wr_data = '0; rd_start = 1'b0; rd_bank = '0; rd_transpose = 1'b0; out_ready = 1'b0;
`ifdef MATRIX_BANK_CLEAR_EN
      clr_en = 1'b0; clr_bank = '0;
`endif
      #3;
      chk("reset_ctrl", 600'({rd_busy, out_valid, out_last, out_idx}), 600'(0));
      chk("reset_data", 600'(out_data), 600'(0));
      chk("reset_wr_ready", 600'(wr_ready), 600'(1));
      @(negedge clk);
      RESET = 1'b1;

      fill_rows(0);
      for (int e = 0; e < DIM; e++) d[e*32 +: 32] = A5;
      write_vec(1, 3, 1'b1, d, 1'b1);

      for (int i = 0; i < 8; i++)
         run_stream(tbl[i].bank, tbl[i].tr, tbl[i].pat, tbl[i].kind, tbl[i].do_wr, 1'b0);

      // Asynchronous reset in the middle of a stream.
      rd_start = 1'b1; rd_bank = 1'b0; rd_transpose = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      guard = 0;
      while (out_idx != 4'd7 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("pre_reset_idx", 600'({out_valid, out_idx}), 600'({1'b1, 4'd7}));
      #2 RESET = 1'b0;
      #1 chk("midreset_ctrl", 600'({rd_busy, out_valid, out_last, out_idx}), 600'(0));
      chk("midreset_data", 600'(out_data), 600'(0));
      out_ready = 1'b0;
      @(negedge clk);
      RESET = 1'b1;
      run_stream(0, 0, 4'b1111, K_ZERO, 1'b0, 1'b0);
      run_stream(1, 1, 4'b1101, K_ZERO, 1'b0, 1'b0);

`ifdef MATRIX_BANK_CLEAR_EN
      fill_rows(1);
      clr_en = 1'b1; clr_bank = 1'b1;
      @(negedge clk);
      clr_en = 1'b0;
      run_stream(1, 0, 4'b1111, K_ZERO, 1'b0, 1'b0);
      fill_rows(0);
      run_stream(0, 0, 4'b1111, K_ROW, 1'b0, 1'b1);
      run_stream(0, 1, 4'b1111, K_COL, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/matrix_bank_stream.md
Name: matrix_bank_stream

Overview:
- Multi-bank square matrix register file for the DMA/vector datapath.
- Each bank holds DIM x DIM words. Any single row or column of any bank can be written in one cycle.
- A sequencer streams a whole bank out one vector per beat over a valid/ready handshake, in normal (row) or transposed (column) order.
- Feeds the vector lanes; replaces the single-bank, combinational-readout register file.

Parameters:
- WORD_W, 32, bits per element.
- DIM, 16, rows = columns per bank (power of 2, >= 2).
- BANKS, 2, number of independent matrix banks (>= 1).
- BW, max($clog2(BANKS),1), bank-select width (derived).
- IW, $clog2(DIM), row/column index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- RESET  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_ready  out  1  write accepted this cycle (combinational).
- wr_bank  in  BW  target bank.
- wr_idx  in  IW  row index (col_mode=0) or column index (col_mode=1).
- wr_col_mode  in  1  0: write row wr_idx; 1: write column wr_idx.
- wr_data  in  DIM*WORD_W  element e at bits [e*WORD_W +: WORD_W].
- rd_start  in  1  start streaming a bank.
- rd_bank  in  BW  bank to stream.
- rd_transpose  in  1  0: emit rows; 1: emit columns.
- rd_busy  out  1  sequencer active.
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DIM*WORD_W  beat payload, same element packing as wr_data.
- out_idx  out  IW  row/column number of the current beat.
- out_last  out  1  current beat is index DIM-1.

Behaviour:
- Reset (async, RESET=0): all bank contents 0; FSM to IDLE; rd_busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
- Write, row mode: bank[b][wr_idx][e] <= wr_data element e, for all e.
- Write, column mode: bank[b][e][wr_idx] <= wr_data element e, for all e.
- A write commits at the clock edge when wr_en && wr_ready.
- wr_ready = !(rd_busy && wr_bank == latched stream bank). Writes to the bank being streamed are dropped, not queued. Writes to other banks proceed concurrently.
- Out-of-range wr_bank (>= BANKS): wr_ready=0, write dropped.
- FSM has two states, IDLE and STREAM.
- IDLE: rd_start=1 latches rd_bank and rd_transpose and moves to STREAM. On the next edge, out_valid=1 with beat 0, so start-to-first-valid latency is 1 cycle. rd_busy rises with the state change.
- Out-of-range rd_bank: rd_start ignored.
- Beat k payload:
  - Normal: row k, element e = bank[r][k][e].
  - Transposed: column k, element e = bank[r][e][k].
- STREAM handshake:
  - While out_valid && !out_ready, out_data, out_idx and out_last are held stable.
  - On out_valid && out_ready with k < DIM-1, beat k+1 loads at the same edge. No bubbles; throughput is 1 beat per cycle.
  - On acceptance of beat DIM-1 (out_last=1): go to IDLE; out_valid=0 and rd_busy=0 next cycle.
- rd_start while rd_busy=1, including the final-accept cycle, is ignored. Minimum gap between streams is therefore 1 idle cycle.
- Beat contents are sampled from the array when the beat register loads. Same-cycle writes to other banks do not affect it. The streamed bank cannot change (writes blocked), so a stream is a consistent snapshot.
- out_last = (out_idx == DIM-1) && out_valid.
- Reset asserted mid-stream aborts immediately: out_valid=0, state IDLE, all contents 0.

Optional Feature:
- Macro: MATRIX_BANK_CLEAR_EN.
- Defined: adds input clr_en (1) and clr_bank (BW).
  - clr_en zeroes every element of clr_bank in one cycle.
  - Clear is ignored if clr_bank is the streaming bank.
  - Clear takes priority over a same-cycle write to the same bank.
- Undefined: ports absent; banks are cleared only by RESET.

Test Plan:
- Row writes 0..15 to bank 0 with element e of row r = r*16+e; stream with rd_transpose=0 and out_ready=1 -> 16 consecutive beats, beat k element e = k*16+e; out_last only on beat 15; rd_busy drops the cycle after.
- Same data, rd_transpose=1 -> beat k element e = e*16+k.
- Column write idx 3 of bank 1 with all elements 0xA5A5A5A5, then row stream -> every beat has element 3 = 0xA5A5A5A5, all others 0.
- Stream bank 0 with out_ready toggling 1,0,0,1,...: data held stable while stalled; 16 unique beats in order. Writes to bank 0 during the stream -> wr_ready=0, contents unchanged. Write to bank 1 -> committed.
- Pull RESET low at beat 7 of a stream -> out_valid=0 asynchronously; subsequent stream of bank 0 returns all zeros.
- MATRIX_BANK_CLEAR_EN: clear bank 1 after filling it -> stream yields zeros; a clear of the streaming bank is ignored.
